// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator.
//
// Raster-ordered pixels are accepted one per cycle when ena & pix_valid. Two
// IMG_W-deep line buffers supply the two rows above the incoming pixel. The
// resulting 3-pixel column is shifted into a 3x3 window. Once the window lies
// fully inside the image, it is published with a one-cycle win_valid pulse.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   ena          design enable; low holds all state
//   pix_in       pixel data (PIX_W bits)
//   pix_valid    pixel qualifier
//   sof          start of frame, marks pixel (0,0) when qualified
//   win_out      9 pixels, slice k=3*i+j at [PIX_W*k +: PIX_W]
//                (i = row, 0 at top; j = column, 0 at left; k=8 is newest)
//   win_valid    one-cycle pulse; win_out/win_row/win_col are valid
//   win_row      top-left row of the window
//   win_col      top-left column of the window
//   frame_done   one-cycle pulse after the last pixel of a frame
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [9*PIX_W-1:0]       win_out,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0] row, row_nxt, cur_row;
  logic [CW-1:0] col, col_nxt, cur_col;

  logic accept;
  logic take;    // accepted pixel belongs to the current frame
  logic last;    // accepted pixel is the bottom-right pixel
  logic win_ok;  // accepted pixel completes an in-image window

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb0_out, lb1_out;

  logic [PIX_W-1:0] win     [9];
  logic [PIX_W-1:0] win_nxt [9];
  logic [9*PIX_W-1:0] win_pack;

  assign accept  = ena & pix_valid;
  assign lb0_out = lb0[IMG_W-1];
  assign lb1_out = lb1[IMG_W-1];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The coordinate of the accepted pixel is (0,0) whenever sof is seen, even
  // mid-frame. Window validity is derived from these coordinates only, so the
  // stale line-buffer data left behind by a restart is never flagged valid.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    last      = 1'b0;
    cur_row   = row;
    cur_col   = col;
    if (accept) begin
      case (state)
        IDLE: begin
          if (sof) begin
            take      = 1'b1;
            cur_row   = '0;
            cur_col   = '0;
            state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          take = 1'b1;
          if (sof) begin
            cur_row = '0;
            cur_col = '0;
          end else if (row == ROW_LAST && col == COL_LAST) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign win_ok = take && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

  // ----------------------------------------------------------- counters
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (take) begin
      if (last) begin
        row_nxt = '0;
        col_nxt = '0;
      end else if (cur_col == COL_LAST) begin
        row_nxt = cur_row + RW'(1);
        col_nxt = '0;
      end else begin
        row_nxt = cur_row;
        col_nxt = cur_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
    end
  end

  // -------------------------------------------------------- line buffers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < IMG_W; n++) begin
        lb0[n] <= '0;
        lb1[n] <= '0;
      end
    end else if (take) begin
      lb0[0] <= pix_in;
      lb1[0] <= lb0_out;
      for (int unsigned n = 1; n < IMG_W; n++) begin
        lb0[n] <= lb0[n-1];
        lb1[n] <= lb1[n-1];
      end
    end
  end

  // -------------------------------------------------------------- window
  // Right column receives {row r-2, row r-1, row r}; older columns move left.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      win_nxt[3*i]     = win[3*i+1];
      win_nxt[3*i + 1] = win[3*i+2];
    end
    win_nxt[2] = lb1_out;
    win_nxt[5] = lb0_out;
    win_nxt[8] = pix_in;
  end

  always_comb begin
    win_pack = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      win_pack[PIX_W*k +: PIX_W] = win_nxt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++) begin
        win[k] <= '0;
      end
    end else if (take) begin
      for (int unsigned k = 0; k < 9; k++) begin
        win[k] <= win_nxt[k];
      end
    end
  end

  // ------------------------------------------------------------- outputs
  // win_out is a separate register so it holds the last published window
  // while the internal window keeps shifting through invalid positions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_out    <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= last;
      if (win_ok) begin
        win_valid <= 1'b1;
        win_out   <= win_pack;
        win_row   <= cur_row - ROW_TWO;
        win_col   <= cur_col - COL_TWO;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench for conv_window_gen (8x8 image, 8-bit
// pixels). Ramp frames carry pixel value base + 8*r + c, so every expected
// window is computed from its coordinates. A negedge monitor checks each
// win_valid pulse against the next expected window of the frame.
module tb_conv_window_gen;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ena;
  logic [PW-1:0]       pix_in;
  logic                pix_valid;
  logic                sof;
  logic [9*PW-1:0]     win_out;
  logic                win_valid;
  logic [2:0]          win_row;
  logic [2:0]          win_col;
  logic                frame_done;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int win_cnt  = 0;
  int fd_cnt   = 0;
  int idx      = 0;
  int cur_base = 0;
  bit mon_en   = 1'b0;
  bit hold_en  = 1'b0;
  bit acc_prev = 1'b0;
  logic [9*PW-1:0] last_win = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9*PW-1:0] exp_win(input int r, input int c, input int base);
    logic [9*PW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[PW*(3*i+j) +: PW] = PW'((base + 8*(r+i) + (c+j)) & 255);
    return w;
  endfunction

  always @(posedge clk) acc_prev <= rst_n & ena & pix_valid;

  always @(negedge clk) begin
    if (mon_en) begin
      if (win_valid || frame_done) chk("pulse_needs_accept", acc_prev, 1);
      if (win_valid) begin
        chk("win_row", win_row, idx / (W-2));
        chk("win_col", win_col, idx % (W-2));
        chk("win_out", win_out, exp_win(idx / (W-2), idx % (W-2), cur_base));
        last_win = win_out;
        idx++;
        win_cnt++;
      end else if (hold_en) begin
        chk("win_hold", win_out, last_win);
      end
      if (frame_done) begin
        chk("fd_with_win", win_valid, 1);
        chk("fd_idx", idx, (H-2)*(W-2));
        fd_cnt++;
        idx = 0;
      end
    end
  end

  // Optional gap cycles before the pixel: each gap has either ena or
  // pix_valid low, with junk data and a random sof that must be ignored.
  task automatic send(input logic [PW-1:0] v, input logic s, input int gapmax);
    int gaps;
    gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    for (int g = 0; g < gaps; g++) begin
      ena       = 1'($urandom_range(0, 1));
      pix_valid = ~ena;
      pix_in    = 8'hEE;
      sof       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ena = 1'b1; pix_valid = 1'b1; pix_in = v; sof = s;
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input int base, input int npix, input int gapmax);
    for (int p = 0; p < npix; p++) send(PW'((base + p) & 255), (p == 0), gapmax);
  endtask

  task automatic drain_and_clear();
    repeat (3) @(posedge clk);
    #1;
    win_cnt = 0; fd_cnt = 0; idx = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_win_out"}, win_out, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; pix_in = '0; pix_valid = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1; hold_en = 1'b1;

    // contiguous ramp
    cur_base = 0;
    send_frame(0, 64, 0);
    repeat (3) @(posedge clk); #1;
    chk("ramp_windows", win_cnt, 36);
    chk("ramp_frame_done", fd_cnt, 1);
    drain_and_clear();

    // same ramp with pix_valid gaps and ena drops
    send_frame(0, 64, 3);
    repeat (3) @(posedge clk); #1;
    chk("gap_windows", win_cnt, 36);
    chk("gap_frame_done", fd_cnt, 1);
    drain_and_clear();

    // 10 pixels without sof while IDLE, then a ramp
    for (int p = 0; p < 10; p++) send(PW'(200 + p), 1'b0, 0);
    chk("idle_no_windows", win_cnt, 0);
    send_frame(0, 64, 0);
    repeat (3) @(posedge clk); #1;
    chk("idle_windows", win_cnt, 36);
    chk("idle_frame_done", fd_cnt, 1);
    drain_and_clear();

    // partial frame of 30 pixels (distinct values), then restart with sof
    cur_base = 100;
    send_frame(100, 30, 0);
    repeat (3) @(posedge clk); #1;
    chk("partial_windows", win_cnt, 10);
    chk("partial_frame_done", fd_cnt, 0);
    drain_and_clear();
    cur_base = 0;
    send_frame(0, 64, 0);
    repeat (3) @(posedge clk); #1;
    chk("restart_windows", win_cnt, 36);
    chk("restart_frame_done", fd_cnt, 1);
    drain_and_clear();

    // reset after 40 pixels, then pixels without sof must be ignored
    send_frame(0, 40, 0);
    hold_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_n = 1'b1;
    last_win = '0;
    hold_en = 1'b1;
    chk("prerst_windows", win_cnt, 18);
    chk("prerst_frame_done", fd_cnt, 0);
    drain_and_clear();
    for (int p = 0; p < 30; p++) send(PW'(p), 1'b0, 0);
    repeat (3) @(posedge clk); #1;
    chk("postrst_windows", win_cnt, 0);
    chk("postrst_frame_done", fd_cnt, 0);
    drain_and_clear();

    // back-to-back frames
    send_frame(0, 64, 0);
    send_frame(0, 64, 0);
    repeat (3) @(posedge clk); #1;
    chk("b2b_windows", win_cnt, 72);
    chk("b2b_frame_done", fd_cnt, 2);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
